// File: rtl/memaccess_pkg.sv
// Shared constants, state encoding and operation decode for the memory-access stage.
package memaccess_pkg;

    // Default datapath widths: 32-bit data, 64k-word data memory, 16 registers.
    localparam int MA_WORD  = 32;
    localparam int MA_ADDR  = 16;
    localparam int MA_W_RD  = 4;

    // Load latency counter width; holds latencies 1..7.
    localparam int W_CNT       = 3;
    localparam int MEM_LAT_MAX = (1 << W_CNT) - 1;

    // FSM states: IDLE accepts new work, WAIT counts down an outstanding load.
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    // Operation class of an execute result. A load wins over a simultaneous
    // store, and a store never produces a register writeback.
    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2,
        OP_ALU   = 2'd3
    } op_e;

    function automatic op_e decode_op(input logic ld, input logic st, input logic wb);
        op_e op;
        op = OP_NONE;
        if (ld) begin
            op = OP_LOAD;
        end else if (st) begin
            op = OP_STORE;
        end else if (wb) begin
            op = OP_ALU;
        end
        return op;
    endfunction

endpackage

// File: rtl/memaccess.sv
// Memory-access stage: issues word loads/stores to a synchronous data memory,
// forwards ALU writebacks with one cycle of latency and returns load data as
// register writebacks, stalling execute while a load is outstanding.
module memaccess
    import memaccess_pkg::*;
#(
    parameter int WORD    = MA_WORD,
    parameter int ADDR    = MA_ADDR,
    parameter int W_RD    = MA_W_RD,
    // Cycles from address sample to valid mem_q_i; legal range 1..7.
    parameter int MEM_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            v_i,
    output logic            stall_o,
    input  logic            ld_i,
    input  logic            st_i,
    input  logic [WORD-1:0] maddr_i,
    input  logic [WORD-1:0] sdata_i,
    input  logic            wb_i,
    input  logic [W_RD-1:0] wb_rd_name_i,
    input  logic [WORD-1:0] wb_rd_data_i,
    output logic [ADDR-1:0] mem_a_o,
    output logic            mem_w_o,
    output logic [WORD-1:0] mem_d_o,
    input  logic [WORD-1:0] mem_q_i,
    output logic            wb_o,
    output logic [W_RD-1:0] wb_rd_name_o,
    output logic [WORD-1:0] wb_rd_data_o
);

    // Latency as a counter-width constant so the terminal compare is width-exact.
    localparam logic [W_CNT-1:0] LAT_CNT = W_CNT'(MEM_LAT);

    state_e            state_q;
    logic [W_CNT-1:0]  cnt_q;
    logic [W_RD-1:0]   ld_rd_q;
    logic              wb_q;
    logic [W_RD-1:0]   wb_name_q;
    logic [WORD-1:0]   wb_data_q;

    logic              acc;
    logic              load_done;
    op_e               op;

    // Upper effective-address bits select nothing in a 64k-word memory.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^maddr_i[WORD-1:ADDR];

    // Stall, accept and memory strobes are combinational from the inputs;
    // reset forces stall and write enable low regardless of state.
    always_comb begin
        stall_o   = rst & (state_q == S_WAIT);
        acc       = v_i & ~stall_o;
        op        = decode_op(ld_i, st_i, wb_i);
        load_done = (cnt_q == LAT_CNT);
        mem_a_o   = maddr_i[ADDR-1:0];
        mem_d_o   = sdata_i;
        mem_w_o   = rst & acc & (op == OP_STORE);
    end

    // FSM with counter and registered writeback outputs; a reset drops any
    // in-flight load without ever producing its writeback.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ld_rd_q   <= '0;
            wb_q      <= 1'b0;
            wb_name_q <= '0;
            wb_data_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    wb_q <= 1'b0;
                    if (acc) begin
                        case (op)
                            OP_LOAD: begin
                                state_q <= S_WAIT;
                                cnt_q   <= W_CNT'(1);
                                ld_rd_q <= wb_rd_name_i;
                            end
                            OP_ALU: begin
                                wb_q      <= 1'b1;
                                wb_name_q <= wb_rd_name_i;
                                wb_data_q <= wb_rd_data_i;
                            end
                            default: begin
                                // Stores complete in memory at this edge; nothing to write back.
                            end
                        endcase
                    end
                end
                S_WAIT: begin
                    if (load_done) begin
                        state_q   <= S_IDLE;
                        cnt_q     <= '0;
                        wb_q      <= 1'b1;
                        wb_name_q <= ld_rd_q;
                        wb_data_q <= mem_q_i;
                    end else begin
                        cnt_q <= cnt_q + W_CNT'(1);
                        wb_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    wb_q    <= 1'b0;
                end
            endcase
        end
    end

    assign wb_o         = wb_q;
    assign wb_rd_name_o = wb_name_q;
    assign wb_rd_data_o = wb_data_q;

endmodule

// File: tb/tb_memaccess.sv
// Directed bench for memaccess: a MEM_LAT=1 and a MEM_LAT=3 instance share one
// stimulus bus, each backed by its own behavioural synchronous memory.
module tb_memaccess;

    logic        clk;
    logic        rst;
    logic        v, ld, st, wbi;
    logic [31:0] maddr, sdata, rdd;
    logic [3:0]  rdn;

    logic        stall1, mw1, wb1;
    logic [15:0] ma1;
    logic [31:0] md1, q1, wbd1;
    logic [3:0]  wbn1;

    logic        stall3, mw3, wb3;
    logic [15:0] ma3;
    logic [31:0] md3, q3, wbd3;
    logic [3:0]  wbn3;

    int n_total = 0;
    int n_pass  = 0;

    memaccess #(.MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .v_i(v), .stall_o(stall1), .ld_i(ld), .st_i(st),
        .maddr_i(maddr), .sdata_i(sdata), .wb_i(wbi), .wb_rd_name_i(rdn),
        .wb_rd_data_i(rdd), .mem_a_o(ma1), .mem_w_o(mw1), .mem_d_o(md1),
        .mem_q_i(q1), .wb_o(wb1), .wb_rd_name_o(wbn1), .wb_rd_data_o(wbd1)
    );

    memaccess #(.MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .v_i(v), .stall_o(stall3), .ld_i(ld), .st_i(st),
        .maddr_i(maddr), .sdata_i(sdata), .wb_i(wbi), .wb_rd_name_i(rdn),
        .wb_rd_data_i(rdd), .mem_a_o(ma3), .mem_w_o(mw3), .mem_d_o(md3),
        .mem_q_i(q3), .wb_o(wb3), .wb_rd_name_o(wbn3), .wb_rd_data_o(wbd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memories: 1-cycle read for u_dut1, 3-stage read pipe for u_dut3.
    logic [31:0] mem1 [0:65535];
    logic [31:0] mem3 [0:65535];
    logic [31:0] p0, p1;

    always @(posedge clk) begin
        if (mw1) mem1[ma1] <= md1;
        q1 <= mem1[ma1];
    end

    always @(posedge clk) begin
        if (mw3) mem3[ma3] <= md3;
        p0 <= mem3[ma3];
        p1 <= p0;
        q3 <= p1;
    end

    // Execute never presents a load and a store together.
    always @(posedge clk) begin
        if (v) assert (!(ld && st)) else $error("illegal ld&st stimulus");
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    typedef struct {
        logic        v, ld, st;
        logic [31:0] maddr, sdata;
        logic        wb;
        logic [3:0]  rdn;
        logic [31:0] rdd;
        logic        e_mw;
        logic [15:0] e_ma;
        logic        e_wb;
        logic [3:0]  e_name;
        logic [31:0] e_data;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v_, input logic ld_, input logic st_,
                         input logic [31:0] a_, input logic [31:0] d_,
                         input logic wb_, input logic [3:0] n_, input logic [31:0] r_);
        v = v_; ld = ld_; st = st_; maddr = a_; sdata = d_;
        wbi = wb_; rdn = n_; rdd = r_;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0);
    endtask

    initial begin
        tbl[0] = '{1'b1,1'b0,1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 1'b0, 4'd0, 32'h0,  1'b1, 16'h1234, 1'b0, 4'd0, 32'h0};
        tbl[1] = '{1'b1,1'b0,1'b0, 32'h0000_0000, 32'h0,         1'b1, 4'd1, 32'd5,  1'b0, 16'h0000, 1'b1, 4'd1, 32'd5};
        tbl[2] = '{1'b1,1'b0,1'b0, 32'h0000_0000, 32'h0,         1'b1, 4'd2, 32'd7,  1'b0, 16'h0000, 1'b1, 4'd2, 32'd7};
        tbl[3] = '{1'b0,1'b0,1'b0, 32'h0000_0008, 32'h0,         1'b1, 4'd4, 32'd9,  1'b0, 16'h0008, 1'b0, 4'd0, 32'h0};
        tbl[4] = '{1'b1,1'b0,1'b1, 32'h0000_0020, 32'h1111_2222, 1'b1, 4'd5, 32'h55, 1'b1, 16'h0020, 1'b0, 4'd0, 32'h0};
        tbl[5] = '{1'b1,1'b0,1'b0, 32'h0000_0024, 32'h0,         1'b0, 4'd0, 32'h0,  1'b0, 16'h0024, 1'b0, 4'd0, 32'h0};
        tbl[6] = '{1'b0,1'b0,1'b1, 32'h0000_0030, 32'h3333_4444, 1'b0, 4'd0, 32'h0,  1'b0, 16'h0030, 1'b0, 4'd0, 32'h0};
        tbl[7] = '{1'b1,1'b0,1'b1, 32'hABCD_0010, 32'hCAFE_F00D, 1'b0, 4'd0, 32'h0,  1'b1, 16'h0010, 1'b0, 4'd0, 32'h0};

        // Reset with a store presented: outputs must be quiet.
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 32'h1234, 32'h1, 1'b0, 4'd0, 32'h0);
        step();
        step();
        chk("rst_stall1", 32'(stall1), 32'd0);
        chk("rst_memw1",  32'(mw1),    32'd0);
        chk("rst_memw3",  32'(mw3),    32'd0);
        chk("rst_wb1",    32'(wb1),    32'd0);
        chk("rst_name1",  32'(wbn1),   32'd0);
        chk("rst_data1",  wbd1,        32'd0);
        $display("reset: stall=%0d mem_w=%0d wb=%0d", stall1, mw1, wb1);
        idle();
        rst = 1'b1;
        step();

        // Table: stores, ALU ops and idle cycles on the MEM_LAT=1 instance.
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].v, tbl[i].ld, tbl[i].st, tbl[i].maddr, tbl[i].sdata,
                  tbl[i].wb, tbl[i].rdn, tbl[i].rdd);
            #1;
            chk($sformatf("vec%0d_memw", i),  32'(mw1),    32'(tbl[i].e_mw));
            chk($sformatf("vec%0d_mema", i),  32'(ma1),    32'(tbl[i].e_ma));
            chk($sformatf("vec%0d_stall", i), 32'(stall1), 32'd0);
            step();
            chk($sformatf("vec%0d_wb", i), 32'(wb1), 32'(tbl[i].e_wb));
            if (tbl[i].e_wb) begin
                chk($sformatf("vec%0d_name", i), 32'(wbn1), 32'(tbl[i].e_name));
                chk($sformatf("vec%0d_data", i), wbd1,      tbl[i].e_data);
            end
            $display("vec%0d: a=0x%04h w=%0d wb=%0d rd=%0d data=0x%08h", i, ma1, mw1, wb1, wbn1, wbd1);
        end
        idle();
        step();

        // Load r3 from 0x1234 (written by vec0), MEM_LAT=1.
        drive(1'b1, 1'b1, 1'b0, 32'h1234, 32'h0, 1'b0, 4'd3, 32'h0);
        #1;
        chk("ld1_memw",   32'(mw1),    32'd0);
        chk("ld1_mema",   32'(ma1),    32'h1234);
        chk("ld1_stall0", 32'(stall1), 32'd0);
        step();
        chk("ld1_stall1", 32'(stall1), 32'd1);
        chk("ld1_wb_lo",  32'(wb1),    32'd0);
        step();
        chk("ld1_stall2", 32'(stall1), 32'd0);
        chk("ld1_wb",     32'(wb1),    32'd1);
        chk("ld1_name",   32'(wbn1),   32'd3);
        chk("ld1_data",   wbd1,        32'hDEAD_BEEF);
        $display("load r3: wb=%0d rd=%0d data=0x%08h", wb1, wbn1, wbd1);
        idle();
        step();
        chk("ld1_wb_once", 32'(wb1), 32'd0);

        // Truncated address load r5 from 0xABCD0010 (written by vec7).
        drive(1'b1, 1'b1, 1'b0, 32'hABCD_0010, 32'h0, 1'b0, 4'd5, 32'h0);
        #1;
        chk("trunc_mema", 32'(ma1), 32'h0010);
        step();
        step();
        chk("trunc_wb",   32'(wb1),  32'd1);
        chk("trunc_name", 32'(wbn1), 32'd5);
        chk("trunc_data", wbd1,      32'hCAFE_F00D);
        $display("load r5: a=0x%04h wb=%0d data=0x%08h", ma1, wb1, wbd1);
        idle();
        step();

        // Store immediately followed by load of the same address.
        drive(1'b1, 1'b0, 1'b1, 32'h0050, 32'h0BAD_F00D, 1'b0, 4'd0, 32'h0);
        step();
        drive(1'b1, 1'b1, 1'b0, 32'h0050, 32'h0, 1'b0, 4'd6, 32'h0);
        step();
        step();
        chk("raw_wb",   32'(wb1),  32'd1);
        chk("raw_name", 32'(wbn1), 32'd6);
        chk("raw_data", wbd1,      32'h0BAD_F00D);
        $display("store->load r6: wb=%0d data=0x%08h", wb1, wbd1);
        idle();

        // Clean both instances before the MEM_LAT=3 sequences.
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();

        // MEM_LAT=3 load with an ALU op held behind it.
        drive(1'b1, 1'b0, 1'b1, 32'h0040, 32'h55AA_55AA, 1'b0, 4'd0, 32'h0);
        step();
        drive(1'b1, 1'b1, 1'b0, 32'h0040, 32'h0, 1'b0, 4'd6, 32'h0);
        #1;
        chk("l3_stall_pre", 32'(stall3), 32'd0);
        step();
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("l3_stall_c%0d", k), 32'(stall3), 32'd1);
            chk($sformatf("l3_wb_c%0d", k),    32'(wb3),    32'd0);
            step();
        end
        chk("l3_stall_end", 32'(stall3), 32'd0);
        chk("l3_wb",        32'(wb3),    32'd1);
        chk("l3_name",      32'(wbn3),   32'd6);
        chk("l3_data",      wbd3,        32'h55AA_55AA);
        $display("lat3 load r6: wb=%0d data=0x%08h", wb3, wbd3);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 4'd7, 32'h77);
        #1;
        chk("l3_alu_acc", 32'(stall3), 32'd0);
        step();
        chk("l3_alu_wb",   32'(wb3),  32'd1);
        chk("l3_alu_name", 32'(wbn3), 32'd7);
        chk("l3_alu_data", wbd3,      32'h77);
        $display("lat3 alu r7: wb=%0d data=0x%08h", wb3, wbd3);
        idle();
        step();
        chk("l3_alu_once", 32'(wb3), 32'd0);

        // Asynchronous reset clears a pending writeback immediately.
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 4'd9, 32'h99);
        step();
        chk("ar_wb_pre", 32'(wb3), 32'd1);
        rst = 1'b0;
        #1;
        chk("ar_wb",   32'(wb3),  32'd0);
        chk("ar_name", 32'(wbn3), 32'd0);
        chk("ar_data", wbd3,      32'd0);
        $display("async reset: wb=%0d rd=%0d", wb3, wbn3);
        idle();
        rst = 1'b1;
        step();

        // Reset held two cycles mid-load: no stall, no write, no stale writeback.
        drive(1'b1, 1'b1, 1'b0, 32'h0040, 32'h0, 1'b0, 4'd8, 32'h0);
        step();
        chk("mr_stall_pre", 32'(stall3), 32'd1);
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 32'h0044, 32'h1, 1'b0, 4'd0, 32'h0);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("mr_stall_%0d", k), 32'(stall3), 32'd0);
            chk($sformatf("mr_memw_%0d", k),  32'(mw3),    32'd0);
            chk($sformatf("mr_wb_%0d", k),    32'(wb3),    32'd0);
            if (k < 2) step();
        end
        idle();
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("mr_post_wb_%0d", k),    32'(wb3),    32'd0);
            chk($sformatf("mr_post_stall_%0d", k), 32'(stall3), 32'd0);
        end
        $display("reset mid-load: wb=%0d stall=%0d", wb3, stall3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
